ram_arbiter: RTL and testbench

Two-port arbiter that shares the single data RAM between the core's data port (port A) and an auxiliary master such as a loader, DMA or debug port (port B). Each requester issues a one-cycle read or write strobe and then waits for a done pulse. This matches the core's MEM_ACCESS/MEM_WAIT handshake. The arbiter captures each request, arbitrates round-robin, drives the RAM's level-held strobe/done handshake, and returns read data and completion status to the owning port.

---
 rtl/ram_arbiter_if.sv | 59 +++++
 rtl/ram_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Bundles the two requester ports and the RAM-side handshake of ram_arbiter.
//   Signal names carry the direction as seen from the arbiter (i_ = into the
//   arbiter, o_ = out of the arbiter).
//   Port A / port B : addr, wdata, read/write strobes in; rdata, done, err out
//   RAM side        : addr, wdata, level-held read/write out; rdata, done in
//   Status          : o_busy
//   Modports: slave  = arbiter view
//             master = environment view (requesters and RAM model)
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  // Port A
  logic [ADDR_W-1:0] i_a_addr;
  logic [DATA_W-1:0] i_a_wdata;
  logic              i_a_read;
  logic              i_a_write;
  logic [DATA_W-1:0] o_a_rdata;
  logic              o_a_done;
  logic              o_a_err;
  // Port B
  logic [ADDR_W-1:0] i_b_addr;
  logic [DATA_W-1:0] i_b_wdata;
  logic              i_b_read;
  logic              i_b_write;
  logic [DATA_W-1:0] o_b_rdata;
  logic              o_b_done;
  logic              o_b_err;
  // RAM
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              o_mem_read;
  logic              o_mem_write;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_done;
  // Status
  logic              o_busy;

  modport slave (
    input  i_a_addr, i_a_wdata, i_a_read, i_a_write,
    output o_a_rdata, o_a_done, o_a_err,
    input  i_b_addr, i_b_wdata, i_b_read, i_b_write,
    output o_b_rdata, o_b_done, o_b_err,
    output o_mem_addr, o_mem_wdata, o_mem_read, o_mem_write,
    input  i_mem_rdata, i_mem_done,
    output o_busy
  );

  modport master (
    output i_a_addr, i_a_wdata, i_a_read, i_a_write,
    input  o_a_rdata, o_a_done, o_a_err,
    output i_b_addr, i_b_wdata, i_b_read, i_b_write,
    input  o_b_rdata, o_b_done, o_b_err,
    input  o_mem_addr, o_mem_wdata, o_mem_read, o_mem_write,
    output i_mem_rdata, i_mem_done,
    input  o_busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one data RAM between the core data port (A) and an auxiliary
//   master (B). Each port issues a one-cycle read/write strobe which is
//   captured into a per-port slot; slots are served one at a time with
//   round-robin priority. The RAM sees a level-held strobe until it answers
//   with i_mem_done (or the access times out), then the owning port gets a
//   one-cycle done pulse with read data and an error flag.
//   Ports:
//     i_clk    : clock, rising edge
//     i_rst_n  : asynchronous active-low reset
//     bus      : ram_arbiter_if.slave (port A, port B, RAM handshake, o_busy)
//   Parameters:
//     ADDR_W, DATA_W  : address / data width
//     TIMEOUT_CYCLES  : ACCESS cycles without i_mem_done before abort (0 = off)
module ram_arbiter #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam bit           TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0]   TO_LAST = (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

  // Grant encoding: 0 = port A, 1 = port B.
  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_gnt;
  logic                w_gnt_nxt;
  logic                r_last;
  logic [7:0]          r_cnt;
  logic                r_err;

  // Request slots
  logic                r_a_vld;
  logic                r_a_wr;
  logic [ADDR_W-1:0]   r_a_addr;
  logic [DATA_W-1:0]   r_a_wdata;
  logic                r_b_vld;
  logic                r_b_wr;
  logic [ADDR_W-1:0]   r_b_addr;
  logic [DATA_W-1:0]   r_b_wdata;

  // Per-port read data, held until that port's next completion
  logic [DATA_W-1:0]   r_a_rdata;
  logic [DATA_W-1:0]   r_b_rdata;

  logic                w_a_req;
  logic                w_b_req;
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_access;
  logic                w_resp;
  logic                w_timeout;

  assign w_a_req     = bus.i_a_read | bus.i_a_write;
  assign w_b_req     = bus.i_b_read | bus.i_b_write;
  assign w_sel_wr    = r_gnt ? r_b_wr    : r_a_wr;
  assign w_sel_addr  = r_gnt ? r_b_addr  : r_a_addr;
  assign w_sel_wdata = r_gnt ? r_b_wdata : r_a_wdata;
  assign w_access    = (r_state == ACCESS);
  assign w_resp      = (r_state == RESP);
  assign w_timeout   = TO_EN && (r_cnt == TO_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      if (w_resp) begin
        r_last <= r_gnt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and grant
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      IDLE: begin
        if (r_a_vld || r_b_vld) begin
          w_state_nxt = ACCESS;
          // On a tie the port that was not served last wins.
          w_gnt_nxt   = (r_a_vld && r_b_vld) ? ~r_last : r_b_vld;
        end
      end
      ACCESS: begin
        if (bus.i_mem_done || w_timeout) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timeout counter, error flag and read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      // Counter is zero on every entry into ACCESS.
      if (w_access) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= '0;
      end

      if (w_access) begin
        if (bus.i_mem_done) begin
          r_err <= 1'b0;
          if (!w_sel_wr) begin
            if (r_gnt) begin
              r_b_rdata <= bus.i_mem_rdata;
            end else begin
              r_a_rdata <= bus.i_mem_rdata;
            end
          end
        end else if (w_timeout) begin
          r_err <= 1'b1;
          if (r_gnt) begin
            r_b_rdata <= '0;
          end else begin
            r_a_rdata <= '0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request slots. A slot stays valid from capture until the end of its RESP
  // cycle, so any strobe during that window is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_vld   <= 1'b0;
      r_a_wr    <= 1'b0;
      r_a_addr  <= '0;
      r_a_wdata <= '0;
    end else if (w_a_req && !r_a_vld) begin
      r_a_vld   <= 1'b1;
      r_a_wr    <= bus.i_a_write;
      r_a_addr  <= bus.i_a_addr;
      r_a_wdata <= bus.i_a_wdata;
    end else if (w_resp && !r_gnt) begin
      r_a_vld   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_b_vld   <= 1'b0;
      r_b_wr    <= 1'b0;
      r_b_addr  <= '0;
      r_b_wdata <= '0;
    end else if (w_b_req && !r_b_vld) begin
      r_b_vld   <= 1'b1;
      r_b_wr    <= bus.i_b_write;
      r_b_addr  <= bus.i_b_addr;
      r_b_wdata <= bus.i_b_wdata;
    end else if (w_resp && r_gnt) begin
      r_b_vld   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Memory outputs are decoded from the state register so that an
  // asynchronous reset drops the strobes immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.o_mem_read  = w_access & ~w_sel_wr;
    bus.o_mem_write = w_access &  w_sel_wr;
    bus.o_mem_addr  = w_access ? w_sel_addr  : '0;
    bus.o_mem_wdata = w_access ? w_sel_wdata : '0;

    bus.o_a_done    = w_resp & ~r_gnt;
    bus.o_a_err     = w_resp & ~r_gnt & r_err;
    bus.o_a_rdata   = r_a_rdata;
    bus.o_b_done    = w_resp &  r_gnt;
    bus.o_b_err     = w_resp &  r_gnt & r_err;
    bus.o_b_rdata   = r_b_rdata;

    bus.o_busy      = (r_state != IDLE) | r_a_vld | r_b_vld;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus_if ();

  ram_arbiter #(
    .ADDR_W         (16),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model
  //   Requests become pending when strobed while the port has nothing
  //   outstanding. A transaction starts on the cycle after an idle cycle in
  //   which something was pending, runs min(lat, TO-1)+1 strobe cycles and
  //   completes with a done pulse one cycle later.
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [256];
  bit          vld [2];
  bit          vp  [2];
  bit          wr  [2];
  logic [15:0] addr[2];
  logic [7:0]  wd  [2];
  logic [7:0]  hold[2];
  int          last_port = 1;
  int          cyc = 0;
  bit          in_txn = 0;
  int          owner = 0;
  int          t_start, t_end, t_done, lat;
  int          prev_done = -10;
  bit          t_to;
  logic [7:0]  t_rdata;
  bit          acc_now;

  task automatic step(input bit force_both);
    bit         acc, dn, req, mdone;
    logic [1:0] kind;
    logic [7:0] rv;
    logic [15:0] ra;
    logic [7:0]  rw;

    // Transaction start
    if (!in_txn && (cyc - 1 > prev_done) && (vp[0] || vp[1])) begin
      if (vp[0] && vp[1]) owner = (last_port == 1) ? 0 : 1;
      else                owner = vp[1] ? 1 : 0;
      in_txn  = 1;
      t_start = cyc;
      if ($urandom_range(0, 3) == 0) lat = $urandom_range(TO - 1, TO + 3);
      else                           lat = $urandom_range(0, 5);
      t_to    = (lat >= TO);
      t_end   = cyc + (t_to ? TO - 1 : lat);
      t_done  = t_end + 1;
      t_rdata = t_to ? 8'h00 : hold[owner];
    end

    acc = in_txn && (cyc <= t_end);
    dn  = in_txn && (cyc == t_done);
    acc_now = acc;

    chk("mem_read",  32'(bus_if.o_mem_read),  32'(acc && !wr[owner]));
    chk("mem_write", 32'(bus_if.o_mem_write), 32'(acc &&  wr[owner]));
    chk("mem_addr",  32'(bus_if.o_mem_addr),  acc ? 32'(addr[owner]) : 32'd0);
    chk("mem_wdata", 32'(bus_if.o_mem_wdata), acc ? 32'(wd[owner])   : 32'd0);
    chk("a_done",    32'(bus_if.o_a_done),    32'(dn && owner == 0));
    chk("b_done",    32'(bus_if.o_b_done),    32'(dn && owner == 1));
    chk("a_err",     32'(bus_if.o_a_err),     32'(dn && owner == 0 && t_to));
    chk("b_err",     32'(bus_if.o_b_err),     32'(dn && owner == 1 && t_to));
    if (dn) hold[owner] = t_rdata;
    chk("a_rdata",   32'(bus_if.o_a_rdata),   32'(hold[0]));
    chk("b_rdata",   32'(bus_if.o_b_rdata),   32'(hold[1]));
    chk("busy",      32'(bus_if.o_busy),      32'(in_txn || vld[0] || vld[1]));

    // RAM model; done outside an access is random noise that must be ignored
    if (acc) begin
      mdone = !t_to && (cyc == t_start + lat);
      rv    = wr[owner] ? 8'($urandom) : mem[addr[owner][7:0]];
      if (mdone) begin
        if (wr[owner]) mem[addr[owner][7:0]] = wd[owner];
        else           t_rdata = rv;
      end
    end else begin
      mdone = 1'($urandom_range(0, 1));
      rv    = 8'($urandom);
    end
    bus_if.i_mem_done  = mdone;
    bus_if.i_mem_rdata = rv;

    // Requesters
    vp = vld;
    for (int p = 0; p < 2; p++) begin
      req  = force_both || ($urandom_range(0, 3) == 0);
      kind = force_both ? ((p == 0) ? 2'b10 : 2'b01) : 2'($urandom_range(1, 3));
      if (!req) kind = 2'b00;
      ra   = 16'($urandom);
      rw   = 8'($urandom);
      if (p == 0) begin
        bus_if.i_a_read  = kind[0];
        bus_if.i_a_write = kind[1];
        bus_if.i_a_addr  = ra;
        bus_if.i_a_wdata = rw;
      end else begin
        bus_if.i_b_read  = kind[0];
        bus_if.i_b_write = kind[1];
        bus_if.i_b_addr  = ra;
        bus_if.i_b_wdata = rw;
      end
      if (req && !vld[p]) begin
        vld[p]  = 1;
        wr[p]   = kind[1];
        addr[p] = ra;
        wd[p]   = rw;
      end
    end

    if (dn) begin
      vld[owner] = 0;
      last_port  = owner;
      in_txn     = 0;
      prev_done  = cyc;
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    bus_if.i_a_read    = 1'b0;
    bus_if.i_a_write   = 1'b0;
    bus_if.i_a_addr    = '0;
    bus_if.i_a_wdata   = '0;
    bus_if.i_b_read    = 1'b0;
    bus_if.i_b_write   = 1'b0;
    bus_if.i_b_addr    = '0;
    bus_if.i_b_wdata   = '0;
    bus_if.i_mem_done  = 1'b0;
    bus_if.i_mem_rdata = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_read"},  32'(bus_if.o_mem_read),  32'd0);
    chk({tag, "_mem_write"}, 32'(bus_if.o_mem_write), 32'd0);
    chk({tag, "_a_done"},    32'(bus_if.o_a_done),    32'd0);
    chk({tag, "_b_done"},    32'(bus_if.o_b_done),    32'd0);
    chk({tag, "_busy"},      32'(bus_if.o_busy),      32'd0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int p = 0; p < 2; p++) begin
      vld[p] = 0; vp[p] = 0; wr[p] = 0; addr[p] = '0; wd[p] = '0; hold[p] = '0;
    end
    idle_inputs();

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk_quiet("rst");
    chk("rst_mem_addr",  32'(bus_if.o_mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(bus_if.o_mem_wdata), 32'd0);
    chk("rst_a_rdata",   32'(bus_if.o_a_rdata),   32'd0);
    chk("rst_b_rdata",   32'(bus_if.o_b_rdata),   32'd0);
    chk("rst_a_err",     32'(bus_if.o_a_err),     32'd0);
    chk("rst_b_err",     32'(bus_if.o_b_err),     32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // First cycle forces a simultaneous A write / B read so the reset-time
    // tie-break is exercised; everything after is random.
    for (int i = 0; i < 4000; i++) begin
      step(i == 0);
      @(negedge clk);
    end

    // Reset in the middle of an access
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b0);
      if (acc_now) found = 1;
      else @(negedge clk);
    end
    chk("find_access", 32'(found), 32'd1);
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_quiet("postrst");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
